sgd_update: RTL and testbench
=============================

# sgd_update

Single-step stochastic-gradient-descent update engine for a linear regressor in signed fixed point. Given a feature vector, current weights and bias, the target, the prediction, a learning rate and an L2 decay factor, it computes the next weights and bias. It sits after the prediction MAC in the training datapath, and the training controller feeds its registered outputs back as the next `w_in_flat`/`b_in`.

## Interface
- `N_FEATURES`, default 1: number of features / weights.
- `WIDTH`, default 32: word width of every scalar, two's complement.
- `FRACTION`, default 16: fractional bits (Q16.16 at defaults).
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: inputs are valid this cycle, so perform one update.
- `x_flat`, input, N_FEATURES*WIDTH: features; feature i is at bits [i*WIDTH +: WIDTH].
- `w_in_flat`, input, N_FEATURES*WIDTH: current weights, packed the same way.
- `b_in`, input, WIDTH: current bias.
- `y_true`, input, WIDTH: target.
- `y_hat`, input, WIDTH: prediction made with `w_in_flat`/`b_in`.
- `eta`, input, WIDTH: learning rate (Q format).
- `lambda`, input, WIDTH: L2 decay coefficient (Q format).
- `out_valid`, output, 1: pulses for 1 cycle when new results are on the outputs.
- `w_out_flat`, output, N_FEATURES*WIDTH: updated weights.
- `b_out`, output, WIDTH: updated bias.
- `sat_o`, output, 1: at least one arithmetic step of this update saturated.

## Operation
- err = sat(y_hat − y_true).
- Per feature i:
  - g_i = sat(mul(err, x_i) + mul(lambda, w_i)).
  - w_out_i = sat(w_i − mul(eta, g_i)).
- b_out = sat(b_in − mul(eta, err)). There is no decay on the bias.
- mul(a,b):
  - Form the full 2*WIDTH signed product.
  - Add 2^(FRACTION−1) to round half up.
  - Arithmetic shift right by FRACTION.
  - Saturate to WIDTH bits.
- sat(): clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Add and subtract use a WIDTH+1 intermediate before the clamp.
- `sat_o` is the OR of every clamp event in the update: err, every mul, every add/sub, across all features and the bias.
- All inputs are sampled together on the `in_valid` edge. There is no dependence on previous updates other than through the inputs.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k with `in_valid`=1 produce results in the registers after edge k, and `out_valid`=1 during cycle k+1.
- Back-to-back `in_valid` is accepted every cycle at full throughput. No backpressure.
- `in_valid`=0: `w_out_flat`, `b_out` and `sat_o` hold their last values, and `out_valid`=0.
- Reset values: `w_out_flat`=0, `b_out`=0, `sat_o`=0, `out_valid`=0.
- `rst` has priority over `in_valid` in the same cycle. An update in flight is discarded.

## Configuration
- `SGD_L2_DECAY_EN` defined: the lambda·w_i term is included as specified above.
- `SGD_L2_DECAY_EN` undefined:
  - g_i = sat(mul(err, x_i)).
  - The `lambda` port remains but is ignored.
  - No multipliers are built for lambda.

## Structure
- Package `sgd_pkg` holds:
  - saturation limits derived from WIDTH;
  - the rounding constant;
  - saturating add/sub functions that return value plus a saturation flag.
- Sub-module `fxp_mul_sat`: parameterised WIDTH/FRACTION, combinational, outputs the rounded and saturated product plus a sat flag.
  - Instantiated per feature: 1 for err·x, 1 for lambda·w when decay is enabled, 1 for eta·g.
  - Plus 1 for eta·err.
- Registered output stage lives in `sgd_update`.

## Test plan
- Convergence (N=1, Q16.16):
  - Setup: eta=0.02, lambda=0, w=b=0. Run 800 updates, feeding the outputs back as inputs.
  - Stimulus: x = −2+4(i mod 50)/49, y_true = 2x+1, y_hat = w·x+b.
  - Required: final |w−2|≤0.05 and |b−1|≤0.05, with `sat_o`=0 throughout.
- Single step:
  - Stimulus: w=0, b=0, x=1.0, y_true=3.0, y_hat=0, eta=0.5.
  - Required: w_out=1.5 (0x00018000), b_out=1.5, out_valid high exactly 1 cycle after in_valid.
- Saturation:
  - Stimulus: w=32767.0, x=1.0, err=−32768.0 (y_hat=−32768, y_true=0), eta=1.0.
  - Required: w_out=0x7FFFFFFF, sat_o=1.
- Decay:
  - Stimulus: w=2.0, x=1.0, y_hat=y_true, eta=1.0, lambda=0.5.
  - Required: w_out=1.0 with `SGD_L2_DECAY_EN`, and w_out=2.0 without it.
- Hold and reset:
  - Stimulus: in_valid=0 for 5 cycles.
    - Required: outputs unchanged, out_valid=0.
  - Stimulus: assert rst together with in_valid.
    - Required: all outputs 0 on the next cycle.
- Multi-feature (N=3):
  - Stimulus: x=(1,−1,2), w=0, err=−1, eta=0.25.
  - Required: w_out=(0.25, −0.25, 0.5), b_out=0.25.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared fixed-point helpers for the SGD update engine.
//
// Contents:
//   wide_t       - signed working type, wide enough for any product plus rounding.
//   sat_res_t    - value plus saturation flag returned by the clamping helpers.
//   sat_max/min  - saturation limits for a given word width.
//   round_const  - round-half-up constant for a given fraction width.
//   sat_clamp    - clamp a wide value to a signed word of the given width.
//   sat_add/sub  - saturating add/subtract of sign-extended operands.
//
// Word widths up to MaxWidth are supported.
package sgd_pkg;

  localparam int unsigned MaxWidth  = 64;
  localparam int unsigned WideWidth = 2 * MaxWidth;

  typedef logic signed [WideWidth-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } sat_res_t;

  function automatic wide_t sat_max(int unsigned width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(int unsigned width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  function automatic wide_t round_const(int unsigned frac);
    return (frac == 0) ? '0 : (wide_t'(1) <<< (frac - 1));
  endfunction

  function automatic sat_res_t sat_clamp(wide_t v, int unsigned width);
    sat_res_t r;
    if (v > sat_max(width)) begin
      r.value = sat_max(width);
      r.sat   = 1'b1;
    end else if (v < sat_min(width)) begin
      r.value = sat_min(width);
      r.sat   = 1'b1;
    end else begin
      r.value = v;
      r.sat   = 1'b0;
    end
    return r;
  endfunction

  // Operands are sign-extended word values, so the wide sum is exact and
  // clamps identically to a width+1 intermediate.
  function automatic sat_res_t sat_add(wide_t a, wide_t b, int unsigned width);
    return sat_clamp(a + b, width);
  endfunction

  function automatic sat_res_t sat_sub(wide_t a, wide_t b, int unsigned width);
    return sat_clamp(a - b, width);
  endfunction

endpackage

// File: rtl/sgd_update_mul.sv
// fxp_mul_sat: combinational signed fixed-point multiply.
// Full 2*WIDTH product, round half up at the FRACTION point, arithmetic shift,
// then saturate to WIDTH bits.
//
// Ports:
//   a_i, b_i - signed Q operands (WIDTH bits)
//   p_o      - rounded, saturated product (WIDTH bits)
//   sat_o    - product was clamped
module fxp_mul_sat
  import sgd_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FRACTION = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic             sat_o
);

  localparam int unsigned ProdWidth = 2 * WIDTH;
  typedef logic signed [ProdWidth-1:0] prod_t;

  prod_t    prod;
  wide_t    rounded;
  sat_res_t res;
  logic     unused_hi;

  always_comb begin
    prod    = prod_t'($signed(a_i)) * prod_t'($signed(b_i));
    rounded = (wide_t'(prod) + round_const(FRACTION)) >>> FRACTION;
    res     = sat_clamp(rounded, WIDTH);
  end

  assign p_o       = res.value[WIDTH-1:0];
  assign sat_o     = res.sat;
  assign unused_hi = ^res.value[WideWidth-1:WIDTH];

endmodule

// File: rtl/sgd_update.sv
// sgd_update: single-step SGD update for a linear regressor in signed fixed point.
//   err     = sat(y_hat - y_true)
//   g_i     = sat(mul(err, x_i) [+ mul(lambda, w_i)])
//   w_out_i = sat(w_i - mul(eta, g_i))
//   b_out   = sat(b_in - mul(eta, err))
// Results are registered: one cycle latency, one update per cycle.
//
// Build option: define SGD_L2_DECAY_EN to include the lambda*w_i decay term.
// Without it, lambda is ignored and no lambda multipliers are built.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid          - perform one update with this cycle's inputs
//   x_flat, w_in_flat - features / current weights, element i at [i*WIDTH +: WIDTH]
//   b_in              - current bias
//   y_true, y_hat     - target and prediction
//   eta, lambda       - learning rate and L2 decay coefficient
//   out_valid         - one-cycle pulse when new results are presented
//   w_out_flat, b_out - updated weights and bias (held when idle)
//   sat_o             - some arithmetic step of the last update saturated
module sgd_update
  import sgd_pkg::*;
#(
  parameter int unsigned N_FEATURES = 1,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FRACTION   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [N_FEATURES*WIDTH-1:0] x_flat,
  input  logic [N_FEATURES*WIDTH-1:0] w_in_flat,
  input  logic [WIDTH-1:0]            b_in,
  input  logic [WIDTH-1:0]            y_true,
  input  logic [WIDTH-1:0]            y_hat,
  input  logic [WIDTH-1:0]            eta,
  input  logic [WIDTH-1:0]            lambda,
  output logic                        out_valid,
  output logic [N_FEATURES*WIDTH-1:0] w_out_flat,
  output logic [WIDTH-1:0]            b_out,
  output logic                        sat_o
);

  function automatic wide_t ext(logic [WIDTH-1:0] v);
    return wide_t'($signed(v));
  endfunction

  // Error and bias path
  sat_res_t         err_res;
  logic [WIDTH-1:0] err;
  logic [WIDTH-1:0] eta_err;
  logic             eta_err_sat;
  sat_res_t         b_res;

  assign err_res = sat_sub(ext(y_hat), ext(y_true), WIDTH);
  assign err     = err_res.value[WIDTH-1:0];

  fxp_mul_sat #(
    .WIDTH   (WIDTH),
    .FRACTION(FRACTION)
  ) u_mul_eta_err (
    .a_i  (eta),
    .b_i  (err),
    .p_o  (eta_err),
    .sat_o(eta_err_sat)
  );

  assign b_res = sat_sub(ext(b_in), ext(eta_err), WIDTH);

  // Per-feature weight path
  logic [N_FEATURES*WIDTH-1:0] w_new_flat;
  logic [N_FEATURES-1:0]       feat_sat;

  for (genvar i = 0; i < N_FEATURES; i++) begin : g_feat
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] w_i;
    logic [WIDTH-1:0] err_x;
    logic             err_x_sat;
    logic [WIDTH-1:0] grad;
    logic             grad_sat;
    logic [WIDTH-1:0] eta_grad;
    logic             eta_grad_sat;
    sat_res_t         w_res;
    logic             unused_w;

    assign x_i = x_flat[i*WIDTH +: WIDTH];
    assign w_i = w_in_flat[i*WIDTH +: WIDTH];

    fxp_mul_sat #(
      .WIDTH   (WIDTH),
      .FRACTION(FRACTION)
    ) u_mul_err_x (
      .a_i  (err),
      .b_i  (x_i),
      .p_o  (err_x),
      .sat_o(err_x_sat)
    );

`ifdef SGD_L2_DECAY_EN
    logic [WIDTH-1:0] lam_w;
    logic             lam_w_sat;
    sat_res_t         grad_res;
    logic             unused_grad;

    fxp_mul_sat #(
      .WIDTH   (WIDTH),
      .FRACTION(FRACTION)
    ) u_mul_lam_w (
      .a_i  (lambda),
      .b_i  (w_i),
      .p_o  (lam_w),
      .sat_o(lam_w_sat)
    );

    assign grad_res    = sat_add(ext(err_x), ext(lam_w), WIDTH);
    assign grad        = grad_res.value[WIDTH-1:0];
    assign grad_sat    = grad_res.sat | lam_w_sat;
    assign unused_grad = ^grad_res.value[WideWidth-1:WIDTH];
`else
    // The product is already clamped, so no further clamp is needed here.
    assign grad     = err_x;
    assign grad_sat = 1'b0;
`endif

    fxp_mul_sat #(
      .WIDTH   (WIDTH),
      .FRACTION(FRACTION)
    ) u_mul_eta_grad (
      .a_i  (eta),
      .b_i  (grad),
      .p_o  (eta_grad),
      .sat_o(eta_grad_sat)
    );

    assign w_res                         = sat_sub(ext(w_i), ext(eta_grad), WIDTH);
    assign w_new_flat[i*WIDTH +: WIDTH]  = w_res.value[WIDTH-1:0];
    assign feat_sat[i]                   = err_x_sat | grad_sat | eta_grad_sat | w_res.sat;
    assign unused_w                      = ^w_res.value[WideWidth-1:WIDTH];
  end

`ifndef SGD_L2_DECAY_EN
  logic unused_lambda;
  assign unused_lambda = ^lambda;
`endif

  logic unused_hi;
  assign unused_hi = ^{err_res.value[WideWidth-1:WIDTH], b_res.value[WideWidth-1:WIDTH]};

  logic sat_any;
  assign sat_any = err_res.sat | eta_err_sat | b_res.sat | (|feat_sat);

  // Output register stage
  logic [N_FEATURES*WIDTH-1:0] w_d, w_q;
  logic [WIDTH-1:0]            b_d, b_q;
  logic                        sat_d, sat_q;
  logic                        valid_q;

  always_comb begin
    w_d   = w_q;
    b_d   = b_q;
    sat_d = sat_q;
    if (in_valid) begin
      w_d   = w_new_flat;
      b_d   = b_res.value[WIDTH-1:0];
      sat_d = sat_any;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      valid_q <= in_valid;
    end
  end

  assign w_out_flat = w_q;
  assign b_out      = b_q;
  assign sat_o      = sat_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_sgd_update.sv
// Self-checking bench for sgd_update (3 features, Q16.16).
module tb_sgd_update;

  localparam int N = 3;
  localparam int W = 32;
  localparam int F = 16;
  localparam longint One  = 65536;
  localparam longint MaxV = 64'sd2147483647;
  localparam longint MinV = -64'sd2147483648;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N*W-1:0] x_flat, w_in_flat;
  logic [W-1:0]   b_in, y_true, y_hat, eta, lambda;
  logic           out_valid;
  logic [N*W-1:0] w_out_flat;
  logic [W-1:0]   b_out;
  logic           sat_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sgd_update #(
    .N_FEATURES(N),
    .WIDTH     (W),
    .FRACTION  (F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x_flat    (x_flat),
    .w_in_flat (w_in_flat),
    .b_in      (b_in),
    .y_true    (y_true),
    .y_hat     (y_hat),
    .eta       (eta),
    .lambda    (lambda),
    .out_valid (out_valid),
    .w_out_flat(w_out_flat),
    .b_out     (b_out),
    .sat_o     (sat_o)
  );

  // Stimulus values as real-valued integers (Q16.16 scaled)
  longint tx[N], tw[N];
  longint t_b, t_yt, t_yh, t_eta, t_lam;
  // Expected outputs
  longint e_w[N];
  longint e_b;
  bit     e_sat;
  bit     m_flag;

  // Reference arithmetic on plain integers
  function automatic longint clamp(longint v);
    if (v > MaxV) begin m_flag = 1'b1; return MaxV; end
    if (v < MinV) begin m_flag = 1'b1; return MinV; end
    return v;
  endfunction

  function automatic longint fmul(longint a, longint b);
    return clamp((a * b + One / 2) >>> F);
  endfunction

  task automatic model();
    longint err, g;
    m_flag = 1'b0;
    err = clamp(t_yh - t_yt);
    for (int i = 0; i < N; i++) begin
      g = fmul(err, tx[i]);
`ifdef SGD_L2_DECAY_EN
      g = clamp(g + fmul(t_lam, tw[i]));
`endif
      e_w[i] = clamp(tw[i] - fmul(t_eta, g));
    end
    e_b   = clamp(t_b - fmul(t_eta, err));
    e_sat = m_flag;
  endtask

  task automatic drive(input bit v);
    in_valid = v;
    for (int i = 0; i < N; i++) begin
      x_flat[i*W +: W]    = W'(tx[i]);
      w_in_flat[i*W +: W] = W'(tw[i]);
    end
    b_in   = W'(t_b);
    y_true = W'(t_yt);
    y_hat  = W'(t_yh);
    eta    = W'(t_eta);
    lambda = W'(t_lam);
  endtask

  function automatic longint rnd();
    int v;
    if ($urandom_range(0, 3) == 0) v = int'($urandom);
    else v = int'($urandom_range(0, 32'h80000)) - 262144;
    return longint'(v);
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      tx[i] = rnd();
      tw[i] = rnd();
    end
    t_b   = rnd();
    t_yt  = rnd();
    t_yh  = rnd();
    t_eta = longint'($urandom_range(0, 65536));
    t_lam = longint'($urandom_range(0, 65536));
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      tx[i] = 0;
      tw[i] = 0;
    end
    t_b = 0; t_yt = 0; t_yh = 0; t_eta = 0; t_lam = 0;
  endtask

  task automatic idle();
    drive(1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    randomize_inputs();
    drive(1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (w_out_flat !== '0) begin
      errors++; $display("FAIL reset_w: got %h expected 0", w_out_flat);
    end
    checks++;
    if (b_out !== '0 || sat_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_misc: got b=%h sat=%b valid=%b expected 0/0/0", b_out, sat_o, out_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) e_w[i] = 0;
    e_b = 0; e_sat = 1'b0;
    idle();
  endtask

  task automatic test_single_step();
    clear_inputs();
    tx[0] = One; t_yt = 3 * One; t_eta = One / 2;
    drive(1'b1);
    model();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pre_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    drive(1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL single_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (w_out_flat[0 +: W] !== 32'h0001_8000 || w_out_flat[0 +: W] !== W'(e_w[0])) begin
      errors++; $display("FAIL single_w: got %h expected 00018000", w_out_flat[0 +: W]);
    end
    checks++;
    if (b_out !== 32'h0001_8000 || sat_o !== 1'b0) begin
      errors++; $display("FAIL single_b: got b=%h sat=%b expected 00018000/0", b_out, sat_o);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_post_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_multi_feature();
    logic [W-1:0] want[N];
    want[0] = 32'h0000_4000; want[1] = 32'hFFFF_C000; want[2] = 32'h0000_8000;
    clear_inputs();
    tx[0] = One; tx[1] = -One; tx[2] = 2 * One;
    t_yt = One; t_eta = One / 4;
    drive(1'b1);
    model();
    @(negedge clk);
    drive(1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (w_out_flat[i*W +: W] !== want[i] || want[i] !== W'(e_w[i])) begin
        errors++;
        $display("FAIL multi_w%0d: got %h expected %h", i, w_out_flat[i*W +: W], want[i]);
      end
    end
    checks++;
    if (b_out !== 32'h0000_4000 || sat_o !== 1'b0) begin
      errors++; $display("FAIL multi_b: got b=%h sat=%b expected 00004000/0", b_out, sat_o);
    end
    idle();
  endtask

  task automatic test_saturation();
    clear_inputs();
    tw[0] = 32767 * One; tx[0] = One; t_yh = MinV; t_eta = One;
    drive(1'b1);
    model();
    @(negedge clk);
    drive(1'b0);
    checks++;
    if (w_out_flat[0 +: W] !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL sat_w: got %h expected 7fffffff", w_out_flat[0 +: W]);
    end
    checks++;
    if (sat_o !== 1'b1 || sat_o !== e_sat) begin
      errors++; $display("FAIL sat_flag: got %b expected 1", sat_o);
    end
    checks++;
    if (b_out !== W'(e_b)) begin
      errors++; $display("FAIL sat_b: got %h expected %h", b_out, W'(e_b));
    end
    idle();
  endtask

  task automatic test_decay();
    logic [W-1:0] want;
`ifdef SGD_L2_DECAY_EN
    want = 32'h0001_0000;
`else
    want = 32'h0002_0000;
`endif
    clear_inputs();
    tw[0] = 2 * One; tx[0] = One; t_yt = One / 2; t_yh = One / 2;
    t_eta = One; t_lam = One / 2;
    drive(1'b1);
    model();
    @(negedge clk);
    drive(1'b0);
    checks++;
    if (w_out_flat[0 +: W] !== want || want !== W'(e_w[0])) begin
      errors++; $display("FAIL decay_w: got %h expected %h", w_out_flat[0 +: W], want);
    end
    checks++;
    if (sat_o !== 1'b0) begin
      errors++; $display("FAIL decay_sat: got %b expected 0", sat_o);
    end
    idle();
  endtask

  task automatic test_hold();
    clear_inputs();
    tx[0] = One; tx[1] = 2 * One; tx[2] = -One;
    tw[0] = One / 8; t_b = One / 3; t_yt = -One; t_yh = One; t_eta = One / 16;
    drive(1'b1);
    model();
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      randomize_inputs();
      drive(1'b0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || w_out_flat[0 +: W] !== W'(e_w[0]) ||
          w_out_flat[W +: W] !== W'(e_w[1]) || w_out_flat[2*W +: W] !== W'(e_w[2]) ||
          b_out !== W'(e_b) || sat_o !== e_sat) begin
        errors++;
        $display("FAIL hold_c%0d: got v=%b w=%h b=%h s=%b expected v=0 w0=%h b=%h s=%b",
                 c, out_valid, w_out_flat, b_out, sat_o, W'(e_w[0]), W'(e_b), e_sat);
      end
    end
  endtask

  task automatic test_reset_priority();
    randomize_inputs();
    drive(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0);
    checks++;
    if (w_out_flat !== '0 || b_out !== '0 || sat_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_priority: got v=%b w=%h b=%h s=%b expected all 0",
               out_valid, w_out_flat, b_out, sat_o);
    end
    for (int i = 0; i < N; i++) e_w[i] = 0;
    e_b = 0; e_sat = 1'b0;
    idle();
  endtask

  // Random stimulus; gaps when gaps=1, otherwise in_valid every cycle.
  task automatic test_random(input bit gaps, input int iters);
    bit v;
    for (int k = 0; k < iters; k++) begin
      randomize_inputs();
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(v);
      if (v) model();
      @(negedge clk);
      checks++;
      if (out_valid !== v) begin
        errors++; $display("FAIL rand_valid k%0d: got %b expected %b", k, out_valid, v);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (w_out_flat[i*W +: W] !== W'(e_w[i])) begin
          errors++;
          $display("FAIL rand_w%0d k%0d: got %h expected %h", i, k, w_out_flat[i*W +: W],
                   W'(e_w[i]));
        end
      end
      checks++;
      if (b_out !== W'(e_b) || sat_o !== e_sat) begin
        errors++;
        $display("FAIL rand_b k%0d: got b=%h s=%b expected b=%h s=%b", k, b_out, sat_o,
                 W'(e_b), e_sat);
      end
    end
    idle();
  endtask

  task automatic test_convergence();
    bit     any_sat = 1'b0;
    int     bad = 0;
    longint xq, dw, db;
    clear_inputs();
    t_eta = 1311;  // 0.02
    for (int k = 0; k < 800; k++) begin
      xq = longint'($rtoi((-2.0 + 4.0 * real'(k % 50) / 49.0) * 65536.0));
      tx[0] = xq;
      t_yt  = 2 * xq + One;
      t_yh  = clamp(fmul(tw[0], xq) + t_b);
      drive(1'b1);
      model();
      @(negedge clk);
      if (sat_o !== 1'b0) any_sat = 1'b1;
      if (w_out_flat[0 +: W] !== W'(e_w[0]) || b_out !== W'(e_b)) bad++;
      for (int i = 0; i < N; i++) tw[i] = longint'($signed(w_out_flat[i*W +: W]));
      t_b = longint'($signed(b_out));
    end
    drive(1'b0);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL conv_track: got %0d step mismatches expected 0", bad);
    end
    checks++;
    if (any_sat !== 1'b0) begin
      errors++; $display("FAIL conv_sat: got sat seen expected none");
    end
    dw = tw[0] - 2 * One;
    db = t_b - One;
    if (dw < 0) dw = -dw;
    if (db < 0) db = -db;
    checks++;
    if (dw > 3277) begin
      errors++; $display("FAIL conv_w: got w=%0d expected within 3277 of %0d", tw[0], 2 * One);
    end
    checks++;
    if (db > 3277) begin
      errors++; $display("FAIL conv_b: got b=%0d expected within 3277 of %0d", t_b, One);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    drive(1'b0);
    test_reset();
    test_single_step();
    test_multi_feature();
    test_saturation();
    test_decay();
    test_hold();
    test_reset_priority();
    test_random(1'b1, 300);
    test_random(1'b0, 200);
    test_reset();
    test_convergence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
